// File: rtl/ring_rr_arbiter.sv
// ---------------------------------------------------------------------------
// ring_rr_arbiter
// Round-robin arbiter sharing one resource among N requesters. A one-hot
// priority ring marks the highest-priority requester. The ring moves to the
// position just past a requester when that requester's grant ends. An
// optional hold limit forces a release after MAX_HOLD consecutive grant
// cycles so that every requester makes progress.
//
// Parameters
//   N            number of requesters (2..16)
//   MAX_HOLD     maximum consecutive grant cycles, 0 = unlimited (0..255)
// Ports
//   i_clk          rising-edge clock
//   i_asyncresetn  asynchronous active-low reset
//   i_req          per-requester request level, bit i = requester i
//   o_gnt          registered one-hot grant, all-zero when idle
//   o_gnt_valid    registered, high when o_gnt is non-zero
//   o_gnt_id       binary index of the granted requester, 0 when idle
//   o_ptr          one-hot priority ring
// ---------------------------------------------------------------------------
module ring_rr_arbiter #(
   parameter int N        = 8,
   parameter int MAX_HOLD = 16
) (
   input  logic                 i_clk,
   input  logic                 i_asyncresetn,
   input  logic [N-1:0]         i_req,
   output logic [N-1:0]         o_gnt,
   output logic                 o_gnt_valid,
   output logic [$clog2(N)-1:0] o_gnt_id,
   output logic [N-1:0]         o_ptr
);

   localparam int IDW = $clog2(N);
   localparam int CW  = (MAX_HOLD > 0) ? $clog2(MAX_HOLD + 1) : 1;
   localparam logic [N-1:0]  ONE       = {{(N-1){1'b0}}, 1'b1};
   localparam logic [CW-1:0] HOLD_LAST = CW'((MAX_HOLD > 0) ? (MAX_HOLD - 1) : 0);

   typedef enum logic [0:0] {
      ST_IDLE  = 1'b0,
      ST_GRANT = 1'b1
   } state_t;

   state_t          r_state;
   logic [N-1:0]    r_gnt;
   logic            r_gnt_valid;
   logic [IDW-1:0]  r_gnt_id;
   logic [N-1:0]    r_ptr;
   logic [CW-1:0]   r_cnt;

   logic [IDW-1:0]  w_ptr_idx;
   logic [IDW-1:0]  w_pick_idx;
   logic [N-1:0]    w_pick_onehot;
   logic            w_found;
   logic            w_hold_done;
   logic            w_release;
   logic [CW-1:0]   w_cnt_next;

   // Binary index of the ring bit; the ring is one-hot so OR-ing is exact.
   always_comb begin
      w_ptr_idx = '0;
      for (int i = 0; i < N; i++) begin
         w_ptr_idx = w_ptr_idx | (r_ptr[i] ? IDW'(i) : '0);
      end
   end

   // First requesting index at or after the ring position, wrapping N-1 -> 0.
   always_comb begin
      int  s;
      int  j;
      logic sel;
      s             = 0;
      j             = 0;
      sel           = 1'b0;
      w_found       = 1'b0;
      w_pick_idx    = '0;
      w_pick_onehot = '0;
      for (int k = 0; k < N; k++) begin
         s   = int'(w_ptr_idx) + k;
         j   = (s >= N) ? (s - N) : s;
         // Only the first hit in search order may contribute.
         sel = !w_found && i_req[j];
         w_pick_idx    = w_pick_idx    | (sel ? IDW'(j) : '0);
         w_pick_onehot = w_pick_onehot | (sel ? (ONE << j) : '0);
         w_found       = w_found | sel;
      end
   end

   // Release decision and hold-counter next value while granting.
   always_comb begin
      w_hold_done = (MAX_HOLD > 0) && (r_cnt == HOLD_LAST);
      w_release   = !i_req[r_gnt_id] || w_hold_done;
      w_cnt_next  = (MAX_HOLD > 0) ? (r_cnt + CW'(1)) : '0;
   end

   // Arbitration state machine with registered grant outputs and ring.
   always_ff @(posedge i_clk or negedge i_asyncresetn) begin
      if (!i_asyncresetn) begin
         r_state     <= ST_IDLE;
         r_gnt       <= '0;
         r_gnt_valid <= 1'b0;
         r_gnt_id    <= '0;
         r_ptr       <= ONE;
         r_cnt       <= '0;
      end else begin
         case (r_state)
            ST_IDLE: begin
               if (w_found) begin
                  r_gnt       <= w_pick_onehot;
                  r_gnt_valid <= 1'b1;
                  r_gnt_id    <= w_pick_idx;
                  r_cnt       <= '0;
                  r_state     <= ST_GRANT;
               end else begin
                  r_gnt       <= '0;
                  r_gnt_valid <= 1'b0;
                  r_gnt_id    <= '0;
                  r_cnt       <= '0;
                  r_state     <= ST_IDLE;
               end
            end
            ST_GRANT: begin
               if (w_release) begin
                  r_gnt       <= '0;
                  r_gnt_valid <= 1'b0;
                  r_gnt_id    <= '0;
                  r_cnt       <= '0;
                  // Rotating the grant itself gives (GNT_ID+1) mod N.
                  r_ptr       <= {r_gnt[N-2:0], r_gnt[N-1]};
                  r_state     <= ST_IDLE;
               end else begin
                  r_cnt       <= w_cnt_next;
                  r_state     <= ST_GRANT;
               end
            end
            default: begin
               r_state     <= ST_IDLE;
               r_gnt       <= '0;
               r_gnt_valid <= 1'b0;
               r_gnt_id    <= '0;
               r_ptr       <= ONE;
               r_cnt       <= '0;
            end
         endcase
      end
   end

   assign o_gnt       = r_gnt;
   assign o_gnt_valid = r_gnt_valid;
   assign o_gnt_id    = r_gnt_id;
   assign o_ptr       = r_ptr;

endmodule

// File: tb/tb_ring_rr_arbiter.sv
// ---------------------------------------------------------------------------
// tb_ring_rr_arbiter
// Three arbiters (MAX_HOLD = 16, 4, 0) share a clock and reset. A queue-free
// behavioural model tracks, per instance, the granted index, the priority
// index and the number of cycles granted so far, and is compared against the
// outputs on every falling clock edge. Directed literal checks pin the model.
// ---------------------------------------------------------------------------
module tb_ring_rr_arbiter;

   typedef struct {
      int gid;    // granted index, -1 when idle
      int pidx;   // priority index
      int held;   // cycles the current grant has been visible
   } model_t;

   localparam model_t RST_M = '{gid: -1, pidx: 0, held: 0};

   logic       clk    = 1'b0;
   logic       clk_en = 1'b0;
   logic       rst_n  = 1'b1;
   logic [7:0] req16  = 8'h00;
   logic [7:0] req4   = 8'h00;
   logic [7:0] req0   = 8'h00;

   logic [7:0] gnt16, gnt4, gnt0;
   logic       vld16, vld4, vld0;
   logic [2:0] id16,  id4,  id0;
   logic [7:0] ptr16, ptr4, ptr0;

   model_t m16 = RST_M;
   model_t m4  = RST_M;
   model_t m0  = RST_M;

   int n_checks = 0;
   int n_errors = 0;

   ring_rr_arbiter #(.N(8), .MAX_HOLD(16)) u_dut16 (
      .i_clk(clk), .i_asyncresetn(rst_n), .i_req(req16),
      .o_gnt(gnt16), .o_gnt_valid(vld16), .o_gnt_id(id16), .o_ptr(ptr16));

   ring_rr_arbiter #(.N(8), .MAX_HOLD(4)) u_dut4 (
      .i_clk(clk), .i_asyncresetn(rst_n), .i_req(req4),
      .o_gnt(gnt4), .o_gnt_valid(vld4), .o_gnt_id(id4), .o_ptr(ptr4));

   ring_rr_arbiter #(.N(8), .MAX_HOLD(0)) u_dut0 (
      .i_clk(clk), .i_asyncresetn(rst_n), .i_req(req0),
      .o_gnt(gnt0), .o_gnt_valid(vld0), .o_gnt_id(id0), .o_ptr(ptr0));

   // Gated clock so the reset check can run with no clock at all.
   initial begin
      forever begin
         #5;
         if (clk_en) clk = ~clk;
      end
   end

   function automatic logic [7:0] onehot(input int i);
      logic [7:0] v;
      v = 8'h00;
      if (i >= 0) v[i] = 1'b1;
      return v;
   endfunction

   // One arbitration step from the rules: pick, hold, or release and rotate.
   function automatic model_t step(input model_t s, input logic [7:0] r, input int m);
      model_t n;
      n = s;
      if (s.gid < 0) begin
         for (int k = 0; k < 8; k++) begin
            int j;
            j = (s.pidx + k) % 8;
            if (n.gid < 0 && r[j]) begin
               n.gid  = j;
               n.held = 1;
            end
         end
      end else if (!r[s.gid] || (m > 0 && s.held == m)) begin
         n.pidx = (s.gid + 1) % 8;
         n.gid  = -1;
         n.held = 0;
      end else begin
         n.held = s.held + 1;
      end
      return n;
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic cmp_inst(input string tag, input model_t m, input logic [7:0] g,
                           input logic v, input logic [2:0] id, input logic [7:0] p);
      check({tag, ".gnt"},   32'(g),  32'(onehot(m.gid)));
      check({tag, ".valid"}, 32'(v),  32'(m.gid >= 0));
      check({tag, ".id"},    32'(id), 32'((m.gid >= 0) ? m.gid : 0));
      check({tag, ".ptr"},   32'(p),  32'(onehot(m.pidx)));
   endtask

   // Model state follows the clock and the asynchronous reset.
   initial begin
      forever begin
         @(posedge clk or negedge rst_n);
         if (!rst_n) begin
            m16 = RST_M;
            m4  = RST_M;
            m0  = RST_M;
         end else begin
            m16 = step(m16, req16, 16);
            m4  = step(m4,  req4,  4);
            m0  = step(m0,  req0,  0);
         end
      end
   end

   // Every falling edge: all outputs of all instances against the model.
   initial begin
      forever begin
         @(negedge clk);
         cmp_inst("m16", m16, gnt16, vld16, id16, ptr16);
         cmp_inst("m4",  m4,  gnt4,  vld4,  id4,  ptr4);
         cmp_inst("m0",  m0,  gnt0,  vld0,  id0,  ptr0);
      end
   end

   task automatic tick();
      @(negedge clk);
   endtask

   task automatic do_reset();
      @(negedge clk);
      #1 rst_n = 1'b0;
      #2 rst_n = 1'b1;
   endtask

   initial begin
      int run;
      bit done;

      // Reset with no clock running.
      req16 = 8'hFF;
      #1 rst_n = 1'b0;
      #2;
      check("rst.gnt",   32'(gnt16), 32'h00);
      check("rst.valid", 32'(vld16), 32'h0);
      check("rst.id",    32'(id16),  32'h0);
      check("rst.ptr",   32'(ptr16), 32'h01);
      clk_en = 1'b1;
      @(negedge clk);
      #1 rst_n = 1'b1;
      tick();
      check("first.gnt", 32'(gnt16), 32'h01);
      req16 = 8'h00;
      tick();
      check("first.rel_ptr", 32'(ptr16), 32'h02);

      // Priority and rotation with REQ=0x81 after reset.
      req16 = 8'h81;
      do_reset();
      tick();
      check("rot.e1_gnt", 32'(gnt16), 32'h01);
      req16 = 8'h80;
      tick();
      check("rot.dead_gnt", 32'(gnt16), 32'h00);
      check("rot.dead_ptr", 32'(ptr16), 32'h02);
      tick();
      check("rot.gnt7",  32'(gnt16), 32'h80);
      check("rot.id7",   32'(id16),  32'h7);
      req16 = 8'h00;
      tick();
      check("rot.wrap_ptr", 32'(ptr16), 32'h01);

      // Wrap-around: move the ring to 0x40, then request bit 4.
      req16 = 8'h20;
      tick();
      check("wrap.gnt5", 32'(gnt16), 32'h20);
      req16 = 8'h00;
      tick();
      check("wrap.ptr40", 32'(ptr16), 32'h40);
      req16 = 8'h10;
      tick();
      check("wrap.gnt4", 32'(gnt16), 32'h10);
      req16 = 8'h00;
      tick();
      check("wrap.ptr20", 32'(ptr16), 32'h20);

      // Forced release after exactly 16 grant cycles.
      req16 = 8'h02;
      run  = 0;
      done = 1'b0;
      for (int i = 0; i < 20; i++) begin
         tick();
         if (!done) begin
            if (gnt16 == 8'h02) run++;
            else done = 1'b1;
         end
      end
      check("hold16.len", 32'(run), 32'd16);
      req16 = 8'h00;
      tick();
      tick();

      // Asynchronous reset in the middle of a grant.
      req16 = 8'h08;
      tick();
      check("mid.gnt", 32'(gnt16), 32'h08);
      @(posedge clk);
      #2 rst_n = 1'b0;
      #1;
      check("mid.rst_gnt",   32'(gnt16), 32'h00);
      check("mid.rst_valid", 32'(vld16), 32'h0);
      check("mid.rst_id",    32'(id16),  32'h0);
      check("mid.rst_ptr",   32'(ptr16), 32'h01);
      #1 rst_n = 1'b1;
      req16 = 8'h00;
      tick();

      // Saturation with MAX_HOLD=4: 4 cycles granted, 1 dead, in order 0..7,0.
      req4 = 8'hFF;
      for (int c = 1; c <= 45; c++) begin
         tick();
         check("fair.gnt", 32'(gnt4),
               32'((((c - 1) % 5) < 4) ? onehot(((c - 1) / 5) % 8) : 8'h00));
      end
      req4 = 8'h00;

      // Unlimited hold: requester 0 keeps the grant for 100 cycles.
      req0 = 8'h05;
      for (int i = 0; i < 100; i++) begin
         tick();
         check("unl.gnt", 32'(gnt0), 32'h01);
         check("unl.ptr", 32'(ptr0), 32'h01);
      end
      req0 = 8'h04;
      tick();
      check("unl.dead_gnt", 32'(gnt0), 32'h00);
      check("unl.dead_ptr", 32'(ptr0), 32'h02);
      tick();
      check("unl.gnt2", 32'(gnt0), 32'h04);
      check("unl.id2",  32'(id0),  32'h2);
      req0 = 8'h00;
      tick();

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
